// File: rtl/k6502_int_seq.sv
// k6502_int_seq: interrupt/reset sequencer for the k6502 core.
// It arbitrates RES > NMI > IRQ > BRK at instruction boundaries. For the
// winner it runs the 7-cycle push/vector-fetch sequence and drives the stack,
// write-enable and ADL pull-down controls. Its outputs are OR-merged into the
// datapath control bundle while busy=1.
// Optional feature macro: K6502_NMI_HIJACK_EN. When it is defined, an NMI that
// becomes pending during T0..T3 of an IRQ/BRK sequence takes over the vector
// fetch. The B bit pushed by a hijacked BRK stays 1, as on the NMOS part.
module k6502_int_seq #(
  parameter int SEQ_LEN  = 7,    // cycles per sequence; only 7 is supported
  parameter bit NMI_SYNC = 1'b1  // 1 = two-flop synchroniser on nmi_n
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_n,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       brk,
  input  logic       sync,
  input  logic       rdy,
  input  logic       i_flag,
  output logic       busy,
  output logic [2:0] step,
  output logic [1:0] kind,
  output logic       write,
  output logic [1:0] push_sel,
  output logic       s_adl,
  output logic       s_dec,
  output logic [2:0] z_adl,
  output logic       vec_fetch,
  output logic       vec_hi,
  output logic       b_flag,
  output logic       set_i,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;  // T0..T(SEQ_LEN-1), tracked by step_q

  localparam logic [1:0] K_IRQ = 2'd0;
  localparam logic [1:0] K_BRK = 2'd1;
  localparam logic [1:0] K_NMI = 2'd2;
  localparam logic [1:0] K_RES = 2'd3;

  localparam logic [2:0] T_PUSH_P  = 3'd3;  // last stack push
  localparam logic [2:0] T_VEC_LO  = 3'd4;
  localparam logic [2:0] T_VEC_HI  = 3'd5;
  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [1:0] kind_q, kind_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       res_pend_q, res_pend_d;
  logic       nmi_prev_q;
  logic       nmi_lvl;
  logic       nmi_edge;
  logic       nmi_clr;
  logic       irq_req;

  // NMI pin conditioning: optional synchroniser, then falling-edge detect.
  generate
    if (NMI_SYNC) begin : g_nmi_sync
      logic nmi_meta_q, nmi_sync_q;
      // Two-flop synchroniser for the asynchronous NMI pin.
      always_ff @(posedge clk) begin
        // NOTE: the synchroniser resets to 1 (pin idle level) so leaving
        // reset never looks like a falling NMI edge.
        if (rst) begin
          nmi_meta_q <= 1'b1;
          nmi_sync_q <= 1'b1;
        end else begin
          nmi_meta_q <= nmi_n;
          nmi_sync_q <= nmi_meta_q;
        end
      end
      assign nmi_lvl = nmi_sync_q;
    end else begin : g_nmi_raw
      assign nmi_lvl = nmi_n;
    end
  endgenerate

  assign nmi_edge = nmi_prev_q & ~nmi_lvl;
  assign irq_req  = ~irq_n & ~i_flag;

  // Next-state logic: arbitration, sequencing, abort and pending latches.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is
    // inferred on paths that leave it untouched.
    state_d    = state_q;
    step_d     = step_q;
    kind_d     = kind_q;
    res_pend_d = res_pend_q | ~res_n;
    nmi_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!res_n) begin
          state_d = ST_HOLD;
          step_d  = 3'd0;
          kind_d  = K_RES;
        end else if (sync && rdy) begin
          if (res_pend_q) begin
            state_d    = ST_RUN;
            step_d     = 3'd0;
            kind_d     = K_RES;
            res_pend_d = 1'b0;
          end else if (nmi_pend_q) begin
            state_d = ST_RUN;
            step_d  = 3'd0;
            kind_d  = K_NMI;
            nmi_clr = 1'b1;
          end else if (irq_req) begin
            state_d = ST_RUN;
            step_d  = 3'd0;
            kind_d  = K_IRQ;
          end else if (brk) begin
            state_d = ST_RUN;
            step_d  = 3'd0;
            kind_d  = K_BRK;
          end
        end
      end
      ST_HOLD: begin
        if (res_n) begin
          state_d    = ST_RUN;
          step_d     = 3'd0;
          kind_d     = K_RES;
          res_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!res_n) begin
          // Reset aborts any sequence; the RES sequence restarts from HOLD.
          state_d = ST_HOLD;
          step_d  = 3'd0;
          kind_d  = K_RES;
        end else if (rdy) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
`ifdef K6502_NMI_HIJACK_EN
          // A pending NMI steals the vector fetch of an IRQ/BRK before T4.
          if (step_q == T_PUSH_P && nmi_pend_q &&
              (kind_q == K_IRQ || kind_q == K_BRK)) begin
            kind_d  = K_NMI;
            nmi_clr = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
      end
    endcase
    // A fresh edge wins over a same-cycle clear so it is never lost.
    nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);
  end

  // State and pending-latch registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      kind_q     <= K_IRQ;
      nmi_pend_q <= 1'b0;
      res_pend_q <= 1'b1;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      kind_q     <= kind_d;
      nmi_pend_q <= nmi_pend_d;
      res_pend_q <= res_pend_d;
      nmi_prev_q <= nmi_lvl;
    end
  end

  logic in_run, push_ph, vec_ph;
  assign in_run  = (state_q == ST_RUN);
  assign push_ph = in_run && (step_q >= 3'd1) && (step_q <= T_PUSH_P);
  assign vec_ph  = in_run && (step_q == T_VEC_LO || step_q == T_VEC_HI);

  // Datapath controls decoded from the current T state and latched kind.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    step      = in_run ? step_q : 3'd0;
    kind      = busy ? kind_q : 2'd0;
    s_adl     = push_ph;
    s_dec     = push_ph & rdy;
    write     = push_ph & (kind_q != K_RES) & res_n;
    push_sel  = push_ph ? 2'(step_q - 3'd1) : 2'd0;
    b_flag    = push_ph && (step_q == T_PUSH_P) && (kind_q == K_BRK);
    vec_fetch = vec_ph;
    vec_hi    = vec_ph && (step_q == T_VEC_HI);
    set_i     = in_run && (step_q == T_VEC_LO) && rdy;
    done      = in_run && (step_q == LAST_STEP) && rdy;
    z_adl     = 3'b000;
    if (vec_ph) begin
      case (kind_q)
        K_NMI:   z_adl = 3'b101;
        K_RES:   z_adl = 3'b011;
        default: z_adl = 3'b001;
      endcase
    end
  end

endmodule

// File: tb/tb_k6502_int_seq.sv
// Testbench for k6502_int_seq: stimulus pushes the expected per-cycle control
// bundle into a queue; a monitor compares every cycle on the falling edge.
module tb_k6502_int_seq;

  localparam logic [1:0] K_IRQ = 2'd0;
  localparam logic [1:0] K_BRK = 2'd1;
  localparam logic [1:0] K_NMI = 2'd2;
  localparam logic [1:0] K_RES = 2'd3;

  logic clk = 1'b0;
  logic rst, res_n, nmi_n, irq_n, brk, sync, rdy, i_flag;
  logic       busy, write, s_adl, s_dec, vec_fetch, vec_hi, b_flag, set_i, done;
  logic [2:0] step, z_adl;
  logic [1:0] kind, push_sel;

  k6502_int_seq dut (
    .clk(clk), .rst(rst), .res_n(res_n), .nmi_n(nmi_n), .irq_n(irq_n),
    .brk(brk), .sync(sync), .rdy(rdy), .i_flag(i_flag),
    .busy(busy), .step(step), .kind(kind), .write(write),
    .push_sel(push_sel), .s_adl(s_adl), .s_dec(s_dec), .z_adl(z_adl),
    .vec_fetch(vec_fetch), .vec_hi(vec_hi), .b_flag(b_flag),
    .set_i(set_i), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [2:0] step;
    logic [1:0] kind;
    logic       write;
    logic [1:0] push_sel;
    logic       s_adl;
    logic       s_dec;
    logic [2:0] z_adl;
    logic       vec_fetch;
    logic       vec_hi;
    logic       b_flag;
    logic       set_i;
    logic       done;
  } obs_t;

  obs_t act;
  assign act = {busy, step, kind, write, push_sel, s_adl, s_dec, z_adl,
                vec_fetch, vec_hi, b_flag, set_i, done};

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;
  bit   nmi_pending = 0;
  bit   res_pending = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: what the bundle must look like in one cycle of a sequence.
  function automatic obs_t model(input logic [1:0] k, input int t, input bit rdy_v,
                                 input bit resn_v, input bit hold);
    obs_t        o;
    logic [15:0] vec;
    o      = '0;
    o.busy = 1'b1;
    o.kind = k;
    if (hold) return o;
    o.step = 3'(t);
    // Pushes: PCH, PCL, P in that order to the stack page.
    if (t >= 1 && t <= 3) begin
      o.s_adl    = 1'b1;
      o.s_dec    = rdy_v;
      o.push_sel = 2'(t - 1);
      o.write    = (k != K_RES) && resn_v;
      o.b_flag   = (t == 3) && (k == K_BRK);
    end
    // Vector low byte bits cleared by pull-downs give the z_adl pattern.
    vec = (k == K_NMI) ? 16'hFFFA : (k == K_RES) ? 16'hFFFC : 16'hFFFE;
    if (t == 4 || t == 5) begin
      o.vec_fetch = 1'b1;
      o.vec_hi    = (t == 5);
      o.z_adl     = ~vec[2:0];
      o.set_i     = (t == 4) && rdy_v;
    end
    if (t == 6) o.done = rdy_v;
    return o;
  endfunction

  // Monitor: one comparison per cycle, away from the active edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_busy", 32'(act), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("trace", 32'(act), 32'(e));
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("missing_cycle", 32'(act), 32'(e));
        end else begin
          check("idle_outputs", 32'(act), 32'(0));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One instruction boundary: sync pulse, then the predicted sequence.
  // stall_at/abort_at/nmi_fall_at = -1 disables that event.
  task automatic do_boundary(input int stall_at, input int stall_len, input int abort_at,
                             input int hold_len, input int nmi_fall_at);
    logic [1:0] w, k_late, kt;
    bit any;
    any = 1'b1;
    if (res_pending)             w = K_RES;
    else if (nmi_pending)        w = K_NMI;
    else if (!irq_n && !i_flag)  w = K_IRQ;
    else if (brk)                w = K_BRK;
    else begin w = K_IRQ; any = 1'b0; end
    sync = 1'b1;
    rdy  = 1'b1;
    cyc();
    sync = 1'b0;
    brk  = 1'b0;
    if (!any) begin
      cyc();
      cyc();
      return;
    end
    if (w == K_RES) res_pending = 1'b0;
    if (w == K_NMI) nmi_pending = 1'b0;
    k_late = w;
    for (int t = 0; t < 7; t++) begin
      if (t == nmi_fall_at) begin
        nmi_n       = 1'b0;
        nmi_pending = 1'b1;
      end
`ifdef K6502_NMI_HIJACK_EN
      if (t == 4 && nmi_pending && (w == K_IRQ || w == K_BRK)) begin
        k_late      = K_NMI;
        nmi_pending = 1'b0;
      end
`endif
      kt = (t >= 4) ? k_late : w;
      if (t == abort_at) begin
        rdy   = 1'b1;
        res_n = 1'b0;
        exp_q.push_back(model(kt, t, 1'b1, 1'b0, 1'b0));
        cyc();
        for (int h = 0; h < hold_len; h++) begin
          exp_q.push_back(model(K_RES, 0, 1'b1, 1'b0, 1'b1));
          cyc();
        end
        res_n = 1'b1;
        exp_q.push_back(model(K_RES, 0, 1'b1, 1'b1, 1'b1));
        cyc();
        for (int t2 = 0; t2 < 7; t2++) begin
          exp_q.push_back(model(K_RES, t2, 1'b1, 1'b1, 1'b0));
          cyc();
        end
        return;
      end
      if (t == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          rdy = 1'b0;
          exp_q.push_back(model(kt, t, 1'b0, 1'b1, 1'b0));
          cyc();
        end
      end
      rdy = 1'b1;
      exp_q.push_back(model(kt, t, 1'b1, 1'b1, 1'b0));
      cyc();
    end
  endtask

  task automatic nmi_fall_settled();
    nmi_n       = 1'b0;
    nmi_pending = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic nmi_release();
    nmi_n = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b1; res_n = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; brk = 1'b0;
    sync = 1'b0; rdy = 1'b1; i_flag = 1'b0;
    repeat (3) cyc();
    check("reset_state", 32'(act), 32'(0));
    armed       = 1'b1;
    res_pending = 1'b1;
    rst         = 1'b0;

    // Power-on RES sequence: no writes, vector 0xFFFC.
    do_boundary(-1, 0, -1, 0, -1);

    // IRQ taken, then masked by I.
    irq_n = 1'b0;
    do_boundary(-1, 0, -1, 0, -1);
    i_flag = 1'b1;
    do_boundary(-1, 0, -1, 0, -1);
    i_flag = 1'b0;

    // sync with rdy=0 must not start anything.
    sync = 1'b1; rdy = 1'b0;
    cyc();
    sync = 1'b0; rdy = 1'b1;
    cyc();

    // BRK together with IRQ: IRQ wins. Then BRK alone.
    brk = 1'b1;
    do_boundary(-1, 0, -1, 0, -1);
    irq_n = 1'b1;
    brk   = 1'b1;
    do_boundary(-1, 0, -1, 0, -1);

    // NMI and IRQ both pending: NMI first, IRQ at the next boundary.
    nmi_fall_settled();
    irq_n = 1'b0;
    do_boundary(-1, 0, -1, 0, -1);
    do_boundary(-1, 0, -1, 0, -1);
    nmi_release();

    // Three-cycle stall in T2, then reset abort in T4.
    do_boundary(2, 3, -1, 0, -1);
    do_boundary(-1, 0, 4, 2, -1);
    irq_n = 1'b1;

    // NMI edge while a BRK is pushing; follow-up boundary takes it if still pending.
    brk = 1'b1;
    do_boundary(-1, 0, -1, 0, 0);
    do_boundary(-1, 0, -1, 0, -1);
    nmi_release();

    // Randomised boundaries.
    for (int it = 0; it < 40; it++) begin
      int sa, sl, ab;
      if ($urandom_range(0, 3) == 0) nmi_fall_settled();
      irq_n  = $urandom_range(0, 1) != 0;
      i_flag = $urandom_range(0, 1) != 0;
      brk    = $urandom_range(0, 1) != 0;
      sa     = int'($urandom_range(0, 7));
      sl     = int'($urandom_range(1, 3));
      ab     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : -1;
      do_boundary((sa == 7) ? -1 : sa, sl, ab, int'($urandom_range(0, 2)), -1);
      irq_n = 1'b1;
      brk   = 1'b0;
      nmi_release();
    end

    cyc();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
